// File: rtl/s_ram_arbiter_if.sv
// s_ram_arbiter_if
// Bundles the per-client request/grant handshake, the per-client write
// path and the shared memory port of the s_ram arbiter.
//   client_access_request  per-client request level (client i at bit i)
//   client_access_granted  per-client grant, one-hot or zero
//   client_wren            per-client write enable
//   client_addr            packed addresses, client i at [i*s_ram_addr_width +: s_ram_addr_width]
//   client_data            packed write data, client i at [i*data_width +: data_width]
//   s_ram_wren/addr/data   memory port driven by the current owner
// master: the requesting side (clients); slave: the arbiter.
interface s_ram_arbiter_if #(
    parameter int data_width       = 8,
    parameter int s_ram_addr_width = 8,
    parameter int num_clients      = 3
);
    logic [num_clients-1:0]                  client_access_request;
    logic [num_clients-1:0]                  client_access_granted;
    logic [num_clients-1:0]                  client_wren;
    logic [num_clients*s_ram_addr_width-1:0] client_addr;
    logic [num_clients*data_width-1:0]       client_data;
    logic                                    s_ram_wren;
    logic [s_ram_addr_width-1:0]             s_ram_addr;
    logic [data_width-1:0]                   s_ram_data;

    modport master (
        output client_access_request,
        output client_wren,
        output client_addr,
        output client_data,
        input  client_access_granted,
        input  s_ram_wren,
        input  s_ram_addr,
        input  s_ram_data
    );

    modport slave (
        input  client_access_request,
        input  client_wren,
        input  client_addr,
        input  client_data,
        output client_access_granted,
        output s_ram_wren,
        output s_ram_addr,
        output s_ram_data
    );
endinterface

// File: rtl/s_ram_arbiter.sv
// s_ram_arbiter
// Round-robin arbiter for the single-port s_ram. Grants one client at a
// time, holds the grant until that client drops its request, and muxes the
// owner's write path onto the memory port.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   bus        s_ram_arbiter_if.slave (requests, grants, client write
//              paths, memory port)
//   fsm_state  current FSM state (0 = idle, 1 = granted) for observation
//
// Handshake: a client raises client_access_request and holds it for the
// whole transaction. The arbiter answers with client_access_granted one
// edge after picking it; while granted, the client's wren/addr/data reach
// the memory port combinationally. The client ends the transaction by
// dropping its request; the grant falls after the next edge, and one idle
// cycle always separates consecutive owners.
module s_ram_arbiter #(
    parameter int data_width       = 8,
    parameter int s_ram_addr_width = 8,
    parameter int num_clients      = 3
) (
    input  logic            clk,
    input  logic            rst,
    s_ram_arbiter_if.slave  bus,
    output logic            fsm_state
);
    localparam int owner_width = (num_clients > 1) ? $clog2(num_clients) : 1;

    localparam logic [0:0] st_idle    = 1'b0;
    localparam logic [0:0] st_granted = 1'b1;

    logic [0:0]             state;
    logic [owner_width-1:0] owner;
    logic [owner_width-1:0] last_owner;
    logic [num_clients-1:0] grant;

    logic [owner_width-1:0] pick;
    logic                   found;
    logic [num_clients-1:0] grant_next;
    logic [owner_width-1:0] cand;
    int                     idx;

    // Round-robin search: first requester after last_owner, wrapping.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        cand  = '0;
        for (int k = 1; k <= num_clients; k++) begin
            idx  = (int'(last_owner) + k) % num_clients;
            cand = owner_width'(idx);
            if (!found && bus.client_access_request[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        grant_next       = '0;
        grant_next[pick] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= st_idle;
            grant      <= '0;
            owner      <= '0;
            last_owner <= owner_width'(num_clients - 1);
        end else begin
            case (state)
                st_idle: begin
                    if (found) begin
                        owner <= pick;
                        grant <= grant_next;
                        state <= st_granted;
                    end
                end
                st_granted: begin
                    // No preemption: only the owner's own release ends the grant.
                    if (!bus.client_access_request[owner]) begin
                        grant      <= '0;
                        last_owner <= owner;
                        state      <= st_idle;
                    end
                end
                default: begin
                    state <= st_idle;
                    grant <= '0;
                end
            endcase
        end
    end

    assign bus.client_access_granted = grant;
    assign fsm_state                 = state[0];

    // Only the owner's slice is selected; everything else is held at zero
    // while idle so no non-owner ever reaches the memory port.
    always_comb begin
        bus.s_ram_wren = 1'b0;
        bus.s_ram_addr = '0;
        bus.s_ram_data = '0;
        if (state == st_granted) begin
            bus.s_ram_wren = bus.client_wren[owner];
            bus.s_ram_addr = bus.client_addr[owner*s_ram_addr_width +: s_ram_addr_width];
            bus.s_ram_data = bus.client_data[owner*data_width +: data_width];
        end
    end
endmodule

// File: tb/tb_s_ram_arbiter.sv
module tb_s_ram_arbiter;
    localparam int dw = 8;
    localparam int aw = 8;
    localparam int nc = 3;

    logic clk;
    logic rst;
    logic fsm_state;
    int   errors;
    int   checks;

    s_ram_arbiter_if #(.data_width(dw), .s_ram_addr_width(aw), .num_clients(nc)) bus ();

    s_ram_arbiter #(.data_width(dw), .s_ram_addr_width(aw), .num_clients(nc)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // m_owner = -1 means nobody holds the memory.
    int m_owner;
    int m_last;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1;
            m_last  = nc - 1;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= nc; k++) begin
                if (m_owner < 0 && bus.client_access_request[(m_last + k) % nc])
                    m_owner = (m_last + k) % nc;
            end
        end else if (!bus.client_access_request[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_model(input string tag);
        logic [nc-1:0] eg;
        logic          ew;
        logic [aw-1:0] ea;
        logic [dw-1:0] ed;
        eg = '0; ew = 1'b0; ea = '0; ed = '0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            ew = bus.client_wren[m_owner];
            ea = bus.client_addr[m_owner*aw +: aw];
            ed = bus.client_data[m_owner*dw +: dw];
        end
        chk({tag, "_grant"}, 32'(bus.client_access_granted), 32'(eg));
        chk({tag, "_wren"},  32'(bus.s_ram_wren), 32'(ew));
        chk({tag, "_addr"},  32'(bus.s_ram_addr), 32'(ea));
        chk({tag, "_data"},  32'(bus.s_ram_data), 32'(ed));
        chk({tag, "_onehot"}, 32'($countones(bus.client_access_granted) <= 1), 32'd1);
    endtask

    // ---------------- drivers ----------------
    task automatic set_client(input int i, input bit r, input bit w,
                              input logic [aw-1:0] a, input logic [dw-1:0] d);
        bus.client_access_request[i] = r;
        bus.client_wren[i]           = w;
        bus.client_addr[i*aw +: aw]  = a;
        bus.client_data[i*dw +: dw]  = d;
    endtask

    task automatic clear_all();
        bus.client_access_request = '0;
        bus.client_wren           = '0;
        bus.client_addr           = '0;
        bus.client_data           = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int          gcnt[nc];
    bit          rerq[nc];
    logic [nc-1:0] prev_g;

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        clear_all();

        // Reset held: everything quiet on every cycle.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_grant", 32'(bus.client_access_granted), 32'd0);
            chk("rst_wren",  32'(bus.s_ram_wren), 32'd0);
            chk("rst_addr",  32'(bus.s_ram_addr), 32'd0);
            chk("rst_data",  32'(bus.s_ram_data), 32'd0);
        end
        rst = 1'b0;

        // Client 0 alone.
        set_client(0, 1, 1, 8'h2A, 8'h2A);
        @(negedge clk);
        chk("c0_grant", 32'(bus.client_access_granted), 32'b001);
        chk("c0_wren",  32'(bus.s_ram_wren), 32'd1);
        chk("c0_addr",  32'(bus.s_ram_addr), 32'h2A);
        chk("c0_data",  32'(bus.s_ram_data), 32'h2A);
        check_model("c0");
        set_client(0, 0, 1, 8'h2A, 8'h2A);
        @(negedge clk);
        chk("c0_release", 32'(bus.client_access_granted), 32'd0);
        check_model("c0_rel");

        // Round-robin order with all clients requesting.
        do_reset();
        for (int i = 0; i < nc; i++) begin
            set_client(i, 1, 1, 8'(8'h10 + i), 8'(8'h80 + i));
            gcnt[i] = 0;
            rerq[i] = 0;
        end
        prev_g = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            check_model("rr");
            if (bus.client_access_granted != 0 && bus.client_access_granted != prev_g) begin
                for (int i = 0; i < nc; i++)
                    if (bus.client_access_granted[i]) got_q.push_back(32'(i));
            end
            prev_g = bus.client_access_granted;
            for (int i = 0; i < nc; i++) begin
                if (bus.client_access_granted[i]) begin
                    gcnt[i]++;
                    if (gcnt[i] == 4) begin
                        bus.client_access_request[i] = 1'b0;
                        gcnt[i] = 0;
                        rerq[i] = 1;
                    end
                end else if (rerq[i]) begin
                    bus.client_access_request[i] = 1'b1;
                    rerq[i] = 0;
                end
            end
        end
        exp_q = '{32'd0, 32'd1, 32'd2, 32'd0, 32'd1};
        chk("rr_count", 32'(got_q.size() >= 5), 32'd1);
        for (int k = 0; k < 5 && k < got_q.size(); k++)
            chk("rr_order", got_q[k], exp_q[k]);

        // Isolation: client 0 owns, client 1 drives a conflicting write.
        do_reset();
        set_client(0, 1, 1, 8'h2A, 8'h55);
        @(negedge clk);
        set_client(1, 1, 1, 8'hFF, 8'hFF);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("iso_grant", 32'(bus.client_access_granted), 32'b001);
            chk("iso_addr",  32'(bus.s_ram_addr), 32'h2A);
            chk("iso_data",  32'(bus.s_ram_data), 32'h55);
            check_model("iso");
        end
        bus.client_wren[0] = 1'b0;
        @(negedge clk);
        chk("iso_wren0", 32'(bus.s_ram_wren), 32'd0);
        set_client(0, 0, 0, 8'h2A, 8'h55);
        @(negedge clk);
        chk("iso_dead", 32'(bus.client_access_granted), 32'd0);
        @(negedge clk);
        chk("iso_c1", 32'(bus.client_access_granted), 32'b010);
        check_model("iso_c1");

        // Client 1 releases (last_owner was 0) while 0 and 2 request.
        set_client(1, 0, 0, 8'h00, 8'h00);
        set_client(0, 1, 0, 8'h01, 8'h01);
        set_client(2, 1, 1, 8'h22, 8'h33);
        @(negedge clk);
        chk("rr2_dead", 32'(bus.client_access_granted), 32'd0);
        @(negedge clk);
        chk("rr2_c2", 32'(bus.client_access_granted), 32'b100);
        check_model("rr2_c2");
        bus.client_access_request[2] = 1'b0;
        @(negedge clk);
        chk("rr2_dead2", 32'(bus.client_access_granted), 32'd0);
        @(negedge clk);
        chk("rr2_c0", 32'(bus.client_access_granted), 32'b001);
        check_model("rr2_c0");

        // Asynchronous reset while client 2 is writing.
        do_reset();
        set_client(2, 1, 1, 8'h44, 8'h99);
        @(negedge clk);
        chk("ar_pre", 32'(bus.client_access_granted), 32'b100);
        chk("ar_pre_wren", 32'(bus.s_ram_wren), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_grant", 32'(bus.client_access_granted), 32'd0);
        chk("ar_wren",  32'(bus.s_ram_wren), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        set_client(0, 1, 0, 8'h05, 8'h06);
        @(negedge clk);
        chk("ar_c0", 32'(bus.client_access_granted), 32'b001);
        check_model("ar_c0");

        // Randomized traffic against the model.
        clear_all();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (rst) rst = 1'b0;
            check_model("rnd");
            for (int i = 0; i < nc; i++) begin
                if ($urandom_range(0, 3) == 0)
                    bus.client_access_request[i] = ~bus.client_access_request[i];
                bus.client_wren[i]          = 1'($urandom_range(0, 1));
                bus.client_addr[i*aw +: aw] = 8'($urandom_range(0, 255));
                bus.client_data[i*dw +: dw] = 8'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 79) == 0) rst = 1'b1;
        end
        rst = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
